// File: rtl/mult_div_pkg.sv
// Types shared by the iterative multiplier and divider: FSM state encoding and
// the default iteration-counter width.
package mult_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } mdState_e;

  localparam int unsigned WIDTH_DEFAULT = 32;
  // Wide enough to hold WIDTH itself, not just WIDTH-1.
  localparam int unsigned CNT_W = $clog2(WIDTH_DEFAULT + 1);

endpackage

// File: rtl/mult_abs.sv
// Combinational conditional two's-complement negate. Used for operand magnitude
// and for the final sign fix of the product.
module mult_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mult_func.sv
// Sequential shift-and-add multiplier feeding HI/LO; start/done handshake
// matches the iterative divider.
module mult_func
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  mdState_e             stateQ, stateD;
  logic [2*WIDTH-1:0]   productQ, productD;
  logic [WIDTH-1:0]     mcandQ, mcandD;
  logic [CntW-1:0]      countQ, countD;
  logic                 negQ, negD;
  logic                 doneQ, doneD;

  logic [WIDTH-1:0]     absA, absB;
  logic [2*WIDTH-1:0]   fixProd;
  logic [WIDTH:0]       sum;

  // Most-negative input maps to 2^(WIDTH-1) as an unsigned magnitude, so it stays exact.
  mult_abs #(.WIDTH(WIDTH)) uAbsA (
    .en (is_signed & multiplicand[WIDTH-1]),
    .a  (multiplicand),
    .y  (absA)
  );

  mult_abs #(.WIDTH(WIDTH)) uAbsB (
    .en (is_signed & multiplier[WIDTH-1]),
    .a  (multiplier),
    .y  (absB)
  );

  mult_abs #(.WIDTH(2 * WIDTH)) uFix (
    .en (negQ),
    .a  (productQ),
    .y  (fixProd)
  );

  // Carry bit of the add is kept and shifted into the product's top bit.
  assign sum = {1'b0, productQ[2*WIDTH-1:WIDTH]} + (productQ[0] ? {1'b0, mcandQ} : '0);

  always_comb begin
    stateD   = stateQ;
    productD = productQ;
    mcandD   = mcandQ;
    countD   = countQ;
    negD     = negQ;
    doneD    = doneQ;
    if (start) begin
      mcandD   = absA;
      productD = {{WIDTH{1'b0}}, absB};
      negD     = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      countD   = CntW'(WIDTH);
      doneD    = 1'b0;
      stateD   = StRun;
    end else begin
      unique case (stateQ)
        StRun: begin
          productD = {sum, productQ[WIDTH-1:1]};
          countD   = countQ - 1'b1;
          if (countQ == CntW'(1)) begin
            stateD = StFix;
          end
        end
        StFix: begin
          productD = fixProd;
          doneD    = 1'b1;
          stateD   = StDone;
        end
        StIdle, StDone: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StIdle;
      productQ <= '0;
      mcandQ   <= '0;
      countQ   <= '0;
      negQ     <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      productQ <= productD;
      mcandQ   <= mcandD;
      countQ   <= countD;
      negQ     <= negD;
      doneQ    <= doneD;
    end
  end

  assign busy = (stateQ == StRun) | (stateQ == StFix);
  assign done = doneQ;
  assign hi   = productQ[2*WIDTH-1:WIDTH];
  assign lo   = productQ[WIDTH-1:0];

endmodule

// File: tb/tb_mult_func.sv
// Scoreboard bench for mult_func: stimulus pushes expected products, a monitor
// checks each done rise for value and latency.
module tb_mult_func;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         done;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_func #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .done         (done),
    .busy         (busy),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             e0;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done rise.
  logic prevDone = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (done && !prevDone) begin
        if (expQ.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("product", {hi, lo}, e.prod);
          check("latency", 64'(cyc - e.e0), 64'd33);
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end else if (!done && expQ.size() > 0 && cyc >= expQ[0].e0) begin
        check("busy_running", 64'(busy), 64'd1);
      end
    end
    prevDone <= done;
  end

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic doPush, input logic [2*W-1:0] prod);
    exp_t e;
    @(negedge clk);
    start        = 1'b1;
    is_signed    = sgn;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    if (doPush) begin
      e.prod = prod;
      e.e0   = cyc;
      expQ.push_back(e);
    end
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    is_signed    = 1'($urandom_range(1));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (expQ.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("completion_timeout", 64'(expQ.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [2*W-1:0] held;
    #12;
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runOp(32'd7, 32'd6, 1'b0, 1'b1, 64'd42);
    waitIdle();
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001);
    waitIdle();
    runOp(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    waitIdle();
    runOp(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    waitIdle();
    runOp(32'h8000_0000, 32'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    waitIdle();

    // Restart mid-RUN: only the second operation may complete.
    runOp(32'd9, 32'd9, 1'b0, 1'b0, '0);
    repeat (9) @(negedge clk);
    runOp(32'd2, 32'd3, 1'b0, 1'b1, 64'd6);
    waitIdle();

    // Asynchronous reset mid-RUN, applied away from any clock edge.
    runOp(32'd5, 32'd5, 1'b0, 1'b0, '0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_product", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runOp(32'd0, 32'h1234_5678, 1'b0, 1'b1, 64'd0);
    waitIdle();
    held = {hi, lo};
    check("hold_product_start", held, 64'd0);
    repeat (20) @(negedge clk);
    check("hold_done", 64'(done), 64'd1);
    check("hold_product", {hi, lo}, held);
    check("hold_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_func.md
Name: mult_func

Overview:
- Sequential shift-and-add multiplier.
- The multiply-side partner of the iterative divider in the MIPS datapath; feeds HI/LO for MULT/MULTU.
- Takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product on {hi, lo}.
- Signals completion with a done level, using the same start/done handshake as the divider, so the HI/LO control logic drives both blocks identically.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a multiply; sampled on a rising clk edge.
- is_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU); sampled with start.
- multiplicand  input  WIDTH  operand A; sampled with start.
- multiplier  input  WIDTH  operand B; sampled with start.
- done  output  1  product valid; held until next start or reset.
- busy  output  1  high while a multiply is in progress.
- hi  output  WIDTH  product[2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product[WIDTH-1:0].

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state IDLE, done=0, busy=0;
  - product register = 0, so hi=0 and lo=0;
  - count=0 and neg=0.
  It is effective mid-operation; the multiply in progress is discarded.
- States: IDLE, RUN, FIX, DONE.
- Start edge E0, from any state:
  - mcand <= |multiplicand| if is_signed, else multiplicand.
  - product <= {WIDTH'b0, |multiplier|} if is_signed, else {0, multiplier}.
  - neg <= is_signed & (multiplicand[msb] ^ multiplier[msb]).
  - count <= WIDTH; done <= 0; state <= RUN.
- start in RUN or FIX restarts with the new operands. There is no error or ack.
- Absolute value: |x| = two's-complement negation when msb=1.
  - The most-negative value maps to 2^(WIDTH-1), held as unsigned, so it is exact.
- RUN, each edge:
  - sum = {1'b0, product[2W-1:W]} + (product[0] ? mcand : 0), computed at WIDTH+1 bits.
  - product <= {sum, product[W-1:1]}, a right shift that keeps the carry.
  - count <= count-1.
  - When count==1 at the edge, state <= FIX.
- FIX, one edge:
  - product <= neg ? (~product + 1) : product, at 2*WIDTH bits.
  - done <= 1; state <= DONE.
- DONE: hold product and done until start. In DONE with start=0, start=1 is the only exit.
- Latency: done rises at edge E0+WIDTH+1, which is 33 cycles for WIDTH=32.
- busy = (state==RUN) | (state==FIX), decoded from the state register.
- hi/lo are only meaningful when done=1. During RUN they show partial products; consumers must ignore them.
- Operand inputs may change freely after E0.
- Zero operands take no early exit; latency is constant.
- start held high continuously restarts every cycle, so done never asserts. This is legal.

Decomposition:
- Shared package mult_div_pkg holds:
  - state enum {IDLE, RUN, FIX, DONE}, also usable by the divider FSM;
  - localparam CNT_W = clog2(WIDTH+1).
- One natural sub-module: mult_abs (combinational conditional negate, WIDTH bits, with enable).
  - Instantiated twice for the operands.
  - Reused at 2*WIDTH for the FIX negation.
- Everything else stays in mult_func.

Test Plan:
- Unsigned basic: is_signed=0, A=7, B=6, start 1 cycle.
  - Required: done rises 33 edges after the start edge; hi=0, lo=42; busy high for exactly 32 edges before done.
- Unsigned max: A=B=0xFFFFFFFF.
  - Required: hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed: is_signed=1, A=-3 (0xFFFFFFFD), B=5.
  - Required: {hi,lo}=0xFFFFFFFF_FFFFFFF1 (-15).
- Signed corner: A=B=0x80000000, is_signed=1.
  - Required: hi=0x40000000, lo=0; also A=0x80000000, B=1 → hi=0xFFFFFFFF, lo=0x80000000.
- Restart and reset:
  - Start A=9, B=9; re-pulse start with A=2, B=3 at RUN cycle 10. Required: done 33 edges after the second start, lo=6.
  - Assert reset mid-RUN with no clock edge. Required: done=0, busy=0, hi=lo=0 immediately.
- Zero and hold:
  - A=0, B=0x12345678. Required: lo=0 after the full 33 cycles.
  - Then hold start=0 for 20 cycles. Required: done and product unchanged.
